// File: rtl/decoder_scan_nbit.sv
// Registered active-low N-output decoder with 74138-style enables.
// Direct mode decodes the select input; scan mode steps the active output
// from an internal divided counter for multiplexed digit/column strobing.
module decoder_scan_nbit #(
    parameter int SEL_W    = 3,
    parameter int OUT_N    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             g1,
    input  logic             g2a_n,
    input  logic             g2b_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] x,
    output logic [OUT_N-1:0] y_n,
    output logic [SEL_W-1:0] idx,
    output logic             active,
    output logic             wrap
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [SEL_W-1:0] SCAN_LAST = SEL_W'(OUT_N - 1);
    localparam logic [SEL_W-1:0] SCAN_ONE  = SEL_W'(1);

    logic             en;
    logic             mode_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nxt;
    logic [SEL_W-1:0] scan_q;
    logic [SEL_W-1:0] scan_nxt;
    logic [SEL_W-1:0] sel;
    logic [OUT_N-1:0] y_nxt;
    logic             wrap_nxt;
    logic             drive;

    // One-cold decode; selects at or beyond OUT_N match nothing and stay all ones.
    function automatic logic [OUT_N-1:0] decode_cold(input logic [SEL_W-1:0] s);
        logic [OUT_N-1:0] v;
        v = '1;
        for (int k = 0; k < OUT_N; k++) begin
            if (s == SEL_W'(k)) v[k] = 1'b0;
        end
        return v;
    endfunction

    assign en = g1 & ~g2a_n & ~g2b_n;

    // Next-state for divider/scan counter and the value to present on the outputs.
    always_comb begin
        div_nxt  = div_q;
        scan_nxt = scan_q;
        wrap_nxt = 1'b0;
        sel      = scan_q;
        drive    = en;
        if (!mode) begin
            // Direct decode: counters hold, idx tracks x even when disabled.
            sel = x;
        end else if (!mode_q) begin
            // Scan entry restarts from index 0; a coincident terminal count is dropped.
            div_nxt  = '0;
            scan_nxt = '0;
            sel      = '0;
        end else begin
            if (en) begin
                if (div_q == DIV_LAST) begin
                    div_nxt = '0;
                    if (scan_q == SCAN_LAST) begin
                        scan_nxt = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        scan_nxt = scan_q + SCAN_ONE;
                    end
                end else begin
                    div_nxt = div_q + DIV_ONE;
                end
            end
            sel = scan_nxt;
        end
        y_nxt = drive ? decode_cold(sel) : '1;
    end

    // Register state and outputs so every output changes only on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            div_q  <= '0;
            scan_q <= '0;
            y_n    <= '1;
            idx    <= '0;
            active <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            mode_q <= mode;
            div_q  <= div_nxt;
            scan_q <= scan_nxt;
            y_n    <= y_nxt;
            idx    <= sel;
            active <= ~&y_nxt;
            wrap   <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_scan_nbit.sv
// Directed bench: direct decode, enables, out-of-range selects, scan stepping,
// freeze/resume, mode entry collisions and mid-scan reset.
module tb_decoder_scan_nbit;

    logic       clk = 1'b0;
    logic       rst_n, rst_c_n;
    logic       g1, g2a_n, g2b_n;
    logic       mode, mode_c;
    logic [2:0] x;

    logic [7:0] y_a;  logic [2:0] idx_a;  logic act_a, wrap_a;
    logic [5:0] y_b;  logic [2:0] idx_b;  logic act_b, wrap_b;
    logic [7:0] y_c;  logic [2:0] idx_c;  logic act_c, wrap_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decoder_scan_nbit #(.SEL_W(3), .OUT_N(8), .TICK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
        .mode(mode), .x(x), .y_n(y_a), .idx(idx_a), .active(act_a), .wrap(wrap_a));

    decoder_scan_nbit #(.SEL_W(3), .OUT_N(6), .TICK_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
        .mode(mode), .x(x), .y_n(y_b), .idx(idx_b), .active(act_b), .wrap(wrap_b));

    decoder_scan_nbit #(.SEL_W(3), .OUT_N(8), .TICK_DIV(1)) dut_c (
        .clk(clk), .rst_n(rst_c_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
        .mode(mode_c), .x(x), .y_n(y_c), .idx(idx_c), .active(act_c), .wrap(wrap_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int ey, input int ei, input int eact, input int ew);
        check({tag, ".y_n"},   32'(y_a),    32'(ey));
        check({tag, ".idx"},   32'(idx_a),  32'(ei));
        check({tag, ".active"},32'(act_a),  32'(eact));
        check({tag, ".wrap"},  32'(wrap_a), 32'(ew));
    endtask

    task automatic check_c(input string tag, input int ey, input int ei, input int eact, input int ew);
        check({tag, ".y_n"},   32'(y_c),    32'(ey));
        check({tag, ".idx"},   32'(idx_c),  32'(ei));
        check({tag, ".active"},32'(act_c),  32'(eact));
        check({tag, ".wrap"},  32'(wrap_c), 32'(ew));
    endtask

    initial begin
        rst_n = 1'b0; rst_c_n = 1'b0;
        g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
        mode = 1'b0; mode_c = 1'b0;
        x = 3'd5;

        // Reset held for three edges with x=5 and enabled.
        for (int i = 0; i < 3; i++) begin
            step();
            check_a("reset", 'hFF, 0, 0, 0);
        end
        rst_n = 1'b1;
        step();
        check_a("post_reset", 'hDF, 5, 1, 0);

        // Direct sweep on both OUT_N=8 and OUT_N=6 instances.
        for (int v = 0; v < 8; v++) begin
            x = 3'(v);
            step();
            check_a("sweep_a", 'hFF ^ (1 << v), v, 1, 0);
            check("sweep_b.y_n", 32'(y_b), (v < 6) ? 32'(6'h3F ^ (6'd1 << v)) : 32'h3F);
            check("sweep_b.active", 32'(act_b), (v < 6) ? 32'd1 : 32'd0);
            check("sweep_b.idx", 32'(idx_b), 32'(v));
        end
        x = 3'd2;
        step();
        check("oor_b.x2", 32'(y_b), 32'h3B);

        // Each enable dropped individually.
        x = 3'd3;
        g1 = 1'b0;
        step();
        check_a("g1_off", 'hFF, 3, 0, 0);
        g1 = 1'b1; g2a_n = 1'b1;
        step();
        check_a("g2a_off", 'hFF, 3, 0, 0);
        g2a_n = 1'b0; g2b_n = 1'b1;
        step();
        check_a("g2b_off", 'hFF, 3, 0, 0);
        g2b_n = 1'b0;
        step();
        check_a("en_back", 'hF7, 3, 1, 0);

        // Scan entry then 46 more edges: idx = (n/4)%8, wrap at n=32.
        mode = 1'b1;
        step();
        check_a("scan_entry", 'hFE, 0, 1, 0);
        for (int n = 1; n <= 46; n++) begin
            step();
            check_a("scan", 'hFF ^ (1 << ((n / 4) % 8)), (n / 4) % 8, 1, (n == 32) ? 1 : 0);
        end

        // Now idx=3, divider=2: freeze for 10 edges.
        g1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_a("freeze", 'hFF, 3, 0, 0);
        end
        g1 = 1'b1;
        step();
        check_a("resume1", 'hF7, 3, 1, 0);
        step();
        check_a("resume2", 'hEF, 4, 1, 0);

        // Mode exit takes direct decode on the next edge.
        mode = 1'b0;
        x = 3'd6;
        step();
        check_a("mode_exit", 'hBF, 6, 1, 0);

        // TICK_DIV=1 instance: step every cycle.
        rst_c_n = 1'b1;
        mode_c = 1'b1;
        step();
        check_c("c_entry", 'hFE, 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_c("c_scan", 'hFF ^ (1 << k), k, 1, 0);
        end
        mode_c = 1'b0;
        x = 3'd2;
        step();
        check_c("c_direct", 'hFB, 2, 1, 0);
        mode_c = 1'b1;
        step();
        check_c("c_reentry", 'hFE, 0, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            step();
            check_c("c_scan2", 'hFF ^ (1 << k), k, 1, 0);
        end
        step();
        check_c("c_wrap", 'hFE, 0, 1, 1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check_c("c_scan3", 'hFF ^ (1 << k), k, 1, 0);
        end
        // Scan counter at 7 with terminal count every cycle: re-entry must not wrap.
        mode_c = 1'b0;
        step();
        check_c("c_direct2", 'hFB, 2, 1, 0);
        mode_c = 1'b1;
        step();
        check_c("c_collision", 'hFE, 0, 1, 0);
        step();
        check_c("c_after_coll", 'hFD, 1, 1, 0);
        step();
        check_c("c_after_coll2", 'hFB, 2, 1, 0);
        rst_c_n = 1'b0;
        step();
        check_c("c_reset_mid", 'hFF, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decoder_scan_nbit.md
Name: decoder_scan_nbit

Overview:
Parametrised, registered successor of the 3-to-8 active-low decoder with 74138-style enables (g1, g2a_n, g2b_n). It has two modes. In direct mode it decodes an SEL_W-bit select input. In scan mode an internal divided counter cycles the active output, for multiplexed 7-segment digit and LED-column strobing on the lab boards. All outputs are registered, active-low and glitch-free.

Parameters:
SEL_W, 3, select width in bits (1..5)
OUT_N, 8, number of decoded outputs; must satisfy 2 <= OUT_N <= 2**SEL_W
TICK_DIV, 50000, clk cycles per scan step in scan mode (>= 1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  synchronous active-low reset
g1  input  1  active-high enable
g2a_n  input  1  active-low enable
g2b_n  input  1  active-low enable
mode  input  1  0 = direct decode of x; 1 = auto-scan
x  input  SEL_W  select index (direct mode only)
y_n  output  OUT_N  decoded outputs, active-low, one-cold when active
idx  output  SEL_W  index currently driven low (or last scan index when inactive)
active  output  1  1 when exactly one y_n bit is low
wrap  output  1  one-cycle pulse when the scan index rolls over from OUT_N-1 to 0

Behaviour:
- Reset: all state is sampled on the rising clk edge while rst_n=0. Reset values: y_n = all ones, idx = 0, active = 0, wrap = 0, scan counter = 0, divider = 0. Reset asserted mid-scan aborts the scan immediately, with no partial step.
- Enable: en = g1 & ~g2a_n & ~g2b_n. When en=0, the next-cycle values are y_n = all ones and active = 0.
- Direct mode (mode=0):
  - Latency is 1 cycle: y_n[k] = 0 for k == x, all other bits 1.
  - idx follows x.
  - If x >= OUT_N: y_n = all ones, active = 0, idx still follows x.
  - The scan counter and divider hold their values in this mode.
- Scan mode (mode=1):
  - The divider counts 0..TICK_DIV-1 while en=1.
  - At terminal count the divider returns to 0 and the scan counter advances by 1, wrapping at OUT_N-1 to 0. In the same cycle, wrap pulses for 1 cycle.
  - y_n is one-cold at the scan counter value, with 1-cycle registered latency.
  - idx equals the scan counter.
  - x is ignored.
  - TICK_DIV=1 advances the scan counter every cycle.
- Enable deasserted in scan mode: the divider and scan counter freeze, outputs go inactive, and wrap = 0. On re-enable, scanning resumes from the frozen index and divider value.
- Mode entry: when mode rises (0 to 1, detected against the registered previous mode), the scan counter and divider load 0 and no wrap is generated. The first step comes TICK_DIV cycles later.
- Mode exit: when mode falls (1 to 0), direct decode takes effect on the next edge.
- Simultaneous events: a mode rise on the same cycle as a divider terminal count loads 0 and suppresses wrap. Reset overrides everything.
- Invariant: at most one y_n bit is low at any time. active equals the OR of all ~y_n bits.
- Widths: the divider width is clog2(TICK_DIV) with a minimum of 1. All index comparisons are unsigned.

Test Plan:
- Reset and enables: rst_n=0 for 3 cycles with mode=0, x=5, en=1 -> y_n=8'hFF and active=0 throughout. After rst_n=1, the next edge gives y_n=8'hDF, idx=5, active=1.
- Direct sweep: en=1, x swept 0..7, one value per cycle -> y_n one cycle later equals ~(1<<x). Toggling each of g1=0, g2a_n=1, g2b_n=1 individually -> y_n=8'hFF on the next edge.
- Out of range with OUT_N=6, SEL_W=3: x=6 and x=7 -> y_n=6'h3F, active=0. x=2 -> y_n=6'h3B.
- Scan with TICK_DIV=4, OUT_N=8:
  - The index steps every 4 cycles 0,1,...,7,0.
  - wrap is high for exactly 1 cycle at the 7 to 0 step, i.e. once per 32 cycles.
  - y_n always follows idx.
- Freeze and resume with TICK_DIV=4: drop g1 at idx=3, divider=2, hold 10 cycles -> y_n=FF and idx stays 3. Restore g1 -> idx advances to 4 after 2 more cycles.
- Mode entry and collisions, with TICK_DIV=1:
  - Switch mode 0 to 1 while the scan counter holds 5 -> idx=0 and no wrap.
  - Assert rst_n=0 mid-scan -> all outputs at reset values on the next edge.
